// File: rtl/time_display_scan.sv
// time_display_scan: samples the asynchronous time bus, converts hours/minutes/seconds
// to BCD with a small sequential converter, and scans a 6-digit common-anode
// 7-segment display showing HH.MM.SS.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   mode     0 = 24 h display, 1 = 12 h display
//   seconds  binary seconds 0-59
//   minutes  binary minutes 0-59
//   hours    binary hours 0-23
//   an       digit enables, active-low one-hot (an[0] = seconds ones)
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   dp       decimal point, active-low
//   pm       high in 12 h mode when the sampled hours value is >= 12
module time_display_scan #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pm
);

  localparam int unsigned BUS_W = 18;
  localparam int unsigned DIV   = CLK_HZ / (REFRESH_HZ * 6);
  localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  logic [BUS_W-1:0] sync1, sync2, sync2_q, snap;
  logic             chg;
  logic             snap_ld;

  logic [1:0] state, state_next;
  logic       latch_en, conv_en, load_en;

  logic [5:0] w_s, w_m, ns, nm;
  logic [4:0] w_h, nh;
  logic [2:0] t_s, t_m, t_h;
  logic       w_sd, w_md, w_hd, w_mode, w_pm;

  logic [5:0][3:0] disp;
  logic            pm_q;

  logic [4:0] map_h;
  logic       map_pm, sec_dash, min_dash, hr_dash;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [3:0]    code_c;
  logic [6:0]    seg_c;
  logic          dp_c;

  // A new value is taken only after synchronizer stage 2 held still for two cycles
  assign snap_ld = (sync2 == sync2_q);

  // Input synchronizer, tear-free snapshot and change flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_q <= '0;
      snap    <= '0;
      chg     <= 1'b0;
    end else begin
      sync1   <= {mode, hours, minutes, seconds};
      sync2   <= sync1;
      sync2_q <= sync2;
      if (snap_ld) snap <= sync2;
      // A fresh change wins over the clear so no update is lost
      if (snap_ld && (sync2 != snap)) chg <= 1'b1;
      else if (latch_en)              chg <= 1'b0;
    end
  end

  // 12/24 h mapping and out-of-range detection from the snapshot
  always_comb begin
    sec_dash = (snap[5:0] > 6'd59);
    min_dash = (snap[11:6] > 6'd59);
    hr_dash  = (snap[16:12] > 5'd23);
    map_h    = snap[16:12];
    map_pm   = 1'b0;
    if (snap[17] && !hr_dash) begin
      map_pm = (snap[16:12] >= 5'd12);
      if (snap[16:12] == 5'd0)       map_h = 5'd12;
      else if (snap[16:12] > 5'd12)  map_h = snap[16:12] - 5'd12;
    end
  end

  // Next working values for one repeated-subtraction step
  always_comb begin
    ns = (w_s >= 6'd10) ? w_s - 6'd10 : w_s;
    nm = (w_m >= 6'd10) ? w_m - 6'd10 : w_m;
    nh = (w_h >= 5'd10) ? w_h - 5'd10 : w_h;
  end

  // Converter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Converter next-state and control
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    conv_en    = 1'b0;
    load_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (chg) begin
          latch_en   = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        conv_en = 1'b1;
        if ((ns < 6'd10) && (nm < 6'd10) && (nh < 5'd10)) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_en    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Working registers and atomic display-register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_s <= '0; w_m <= '0; w_h <= '0;
      t_s <= '0; t_m <= '0; t_h <= '0;
      w_sd <= 1'b0; w_md <= 1'b0; w_hd <= 1'b0;
      w_mode <= 1'b0; w_pm <= 1'b0;
      disp <= '0;
      pm_q <= 1'b0;
    end else begin
      if (latch_en) begin
        // Dashed fields start at zero so the conversion stays within five steps
        w_s    <= sec_dash ? 6'd0 : snap[5:0];
        w_m    <= min_dash ? 6'd0 : snap[11:6];
        w_h    <= hr_dash  ? 5'd0 : map_h;
        t_s    <= '0;
        t_m    <= '0;
        t_h    <= '0;
        w_sd   <= sec_dash;
        w_md   <= min_dash;
        w_hd   <= hr_dash;
        w_mode <= snap[17];
        w_pm   <= map_pm;
      end
      if (conv_en) begin
        w_s <= ns;
        w_m <= nm;
        w_h <= nh;
        t_s <= t_s + 3'(w_s >= 6'd10);
        t_m <= t_m + 3'(w_m >= 6'd10);
        t_h <= t_h + 3'(w_h >= 5'd10);
      end
      if (load_en) begin
        disp[0] <= w_sd ? CODE_DASH : w_s[3:0];
        disp[1] <= w_sd ? CODE_DASH : {1'b0, t_s};
        disp[2] <= w_md ? CODE_DASH : w_m[3:0];
        disp[3] <= w_md ? CODE_DASH : {1'b0, t_m};
        disp[4] <= w_hd ? CODE_DASH : w_h[3:0];
        disp[5] <= w_hd ? CODE_DASH :
                   ((w_mode && (t_h == 3'd0)) ? CODE_BLANK : {1'b0, t_h});
        pm_q    <= w_pm;
      end
    end
  end

  // Digit code selection, segment decode and decimal points
  always_comb begin
    case (idx)
      3'd0:    code_c = disp[0];
      3'd1:    code_c = disp[1];
      3'd2:    code_c = disp[2];
      3'd3:    code_c = disp[3];
      3'd4:    code_c = disp[4];
      3'd5:    code_c = disp[5];
      default: code_c = CODE_BLANK;
    endcase
    case (code_c)
      4'd0:      seg_c = 7'h40;
      4'd1:      seg_c = 7'h79;
      4'd2:      seg_c = 7'h24;
      4'd3:      seg_c = 7'h30;
      4'd4:      seg_c = 7'h19;
      4'd5:      seg_c = 7'h12;
      4'd6:      seg_c = 7'h02;
      4'd7:      seg_c = 7'h78;
      4'd8:      seg_c = 7'h00;
      4'd9:      seg_c = 7'h10;
      CODE_DASH: seg_c = 7'h3F;
      default:   seg_c = 7'h7F;
    endcase
    dp_c = !((idx == 3'd4) || (idx == 3'd2) || ((idx == 3'd0) && pm_q));
  end

  // Prescaler, digit index and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
      an    <= 6'h3F;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      if (presc == PW'(DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      an  <= ~(6'b000001 << idx);
      seg <= seg_c;
      dp  <= dp_c;
    end
  end

  assign pm = pm_q;

endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: directed bench for time_display_scan with DIV = 10.
module tb_time_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp, pm;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] cap_seg  [6];
  logic       cap_dp   [6];
  logic       cap_seen [6];

  always #5 clk = ~clk;

  time_display_scan #(.CLK_HZ(600), .REFRESH_HZ(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .pm      (pm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] an_of(input int k);
    logic [5:0] onehot;
    onehot = 6'd1 << k;
    return ~onehot;
  endfunction

  task automatic set_time(input logic m, input logic [4:0] h, input logic [5:0] mi,
                          input logic [5:0] s);
    mode = m; hours = h; minutes = mi; seconds = s;
    repeat (20) @(negedge clk);
  endtask

  // One frame is 60 cycles; 70 samples see every digit at least once
  task automatic capture_frame();
    for (int k = 0; k < 6; k++) cap_seen[k] = 1'b0;
    repeat (70) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        if (an == an_of(k)) begin
          cap_seg[k]  = seg;
          cap_dp[k]   = dp;
          cap_seen[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [41:0] exp_seg,
                             input logic [5:0] exp_dp, input logic exp_pm);
    capture_frame();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s seen d%0d", tag, k), 32'(cap_seen[k]), 32'd1);
      check($sformatf("%s seg d%0d", tag, k), 32'(cap_seg[k]), 32'(exp_seg[k*7 +: 7]));
      check($sformatf("%s dp d%0d", tag, k), 32'(cap_dp[k]), 32'(exp_dp[k]));
    end
    check($sformatf("%s pm", tag), 32'(pm), 32'(exp_pm));
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s an", tag), 32'(an), 32'h3F);
    check($sformatf("%s seg", tag), 32'(seg), 32'h7F);
    check($sformatf("%s dp", tag), 32'(dp), 32'd1);
    check($sformatf("%s pm", tag), 32'(pm), 32'd0);
  endtask

  initial begin : main
    logic seen;
    reset = 1'b0; mode = 1'b0; hours = 5'd0; minutes = 6'd0; seconds = 6'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Scan walk after release: each enable held exactly 10 cycles
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      repeat (10) begin
        @(negedge clk);
        check($sformatf("walk d%0d", k), 32'(an), 32'(an_of(k)));
      end
    end

    set_time(1'b0, 5'd13, 6'd45, 6'd7);
    check_frame("24h 13:45:07", {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78}, 6'b101011, 1'b0);

    set_time(1'b1, 5'd13, 6'd45, 6'd7);
    check_frame("12h 13:45:07", {7'h7F, 7'h79, 7'h19, 7'h12, 7'h40, 7'h78}, 6'b101010, 1'b1);

    set_time(1'b1, 5'd0, 6'd0, 6'd0);
    check_frame("12h 00:00:00", {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 6'b101011, 1'b0);

    set_time(1'b1, 5'd12, 6'd0, 6'd0);
    check_frame("12h 12:00:00", {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 6'b101010, 1'b1);

    set_time(1'b0, 5'd23, 6'd59, 6'd59);
    check_frame("24h 23:59:59", {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}, 6'b101011, 1'b0);

    set_time(1'b0, 5'd24, 6'd60, 6'd7);
    check_frame("24h oor", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h78}, 6'b101011, 1'b0);

    set_time(1'b1, 5'd24, 6'd60, 6'd7);
    check_frame("12h oor", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h78}, 6'b101011, 1'b0);

    // Latency: seconds 07 -> 08 must be in the display registers within 12 cycles
    set_time(1'b0, 5'd13, 6'd45, 6'd7);
    seconds = 6'd8;
    repeat (13) @(negedge clk);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (!seen && an == 6'h3E) begin
        seen = 1'b1;
        check("latency seg d0", 32'(seg), 32'h00);
      end
    end
    check("latency seen d0", 32'(seen), 32'd1);

    // Seconds toggling every cycle never settles, so digit 0 keeps showing 8
    for (int i = 0; i < 50; i++) begin
      seconds = (i % 2 == 0) ? 6'd9 : 6'd8;
      @(negedge clk);
      if (an == 6'h3E) check($sformatf("toggle seg c%0d", i), 32'(seg), 32'h00);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (an == 6'h3E) check($sformatf("post toggle seg c%0d", i), 32'(seg), 32'h00);
    end
    check_frame("24h 13:45:08", {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h00}, 6'b101011, 1'b0);

    // Reset while the converter is mid-conversion and a digit is mid-period
    seconds = 6'd7;
    repeat (7) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("restart an", 32'(an), 32'h3E);
    repeat (12) @(negedge clk);
    check_frame("after reset", {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78}, 6'b101011, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
